// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package dmem_pkg;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/dmem_wait_ctr.sv
// Wait-state down-counter: load presets WAIT_CYCLES-1, enable counts toward zero.
// done is high whenever the count reads zero.
module dmem_wait_ctr
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic enable,
  output logic done
);
  localparam logic [CNT_W-1:0] LOAD_VAL = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/dmem_responder.sv
// Single-port word memory answering one load/store at a time after WAIT_CYCLES wait states.
// Response is a one-cycle ready strobe; stall holds the requester until it arrives.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              stall_o
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int OFF_W = $clog2(WORD_BYTES);

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cap;
  logic              ctr_load;
  logic              ctr_en;
  logic              ctr_done;
  logic              fault;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign idx   = addr_q[IDX_W+OFF_W-1:OFF_W];
  assign fault = (addr_q[OFF_W-1:0] != '0) || ((addr_q >> (IDX_W + OFF_W)) != '0);

  // armed stays low for the first edge after reset release so that edge never accepts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      armed   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (cap) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        wdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    ready_o   = 1'b0;
    err_o     = 1'b0;
    rdata_o   = '0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && armed) begin
          cap = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            ctr_load  = 1'b1;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        if (ctr_done) state_nxt = RESP;
      end
      RESP: begin
        ready_o   = 1'b1;
        err_o     = fault;
        wr_en     = we_q && !fault;
        state_nxt = IDLE;
        if (!we_q && !fault) rdata_o = mem[idx];
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately left out of reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= wdata_q;
  end

  assign stall_o = req_i & ~ready_o;

  dmem_wait_ctr #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (ctr_load),
    .enable(ctr_en),
    .done  (ctr_done)
  );
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, meaning the number of 32-bit words in the storage array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states inserted before each response (0..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk_i and rst_i.
REQ-004 SHALL have port clk_i, input, 1 bit: the system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_i, input, 1 bit: the requester (CPU MEM stage) wants a load or store.
REQ-007 SHALL have port we_i, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port addr_i, input, 32 bits: the byte address.
REQ-009 SHALL have port wdata_i, input, 32 bits: the store data.
REQ-010 SHALL have port rdata_o, output, 32 bits: the load data, valid while ready_o is high.
REQ-011 SHALL have port ready_o, output, 1 bit: a one-cycle response strobe.
REQ-012 SHALL have port err_o, output, 1 bit: an access fault, valid while ready_o is high.
REQ-013 SHALL have port stall_o, output, 1 bit: a combinational pipeline-freeze request to the CPU.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 SHALL, in IDLE, capture addr_i, we_i and wdata_i into internal registers when req_i is 1, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-016 SHALL load the wait counter with WAIT_CYCLES-1 on entry to WAIT, decrement it each cycle, and go to RESP in the cycle after the counter reads 0.
REQ-017 SHALL, in RESP, drive ready_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL place ready_o in the cycle n+1+WAIT_CYCLES for a request sampled in cycle n.
REQ-019 SHALL accept new requests only in IDLE; req_i in WAIT or RESP SHALL be ignored, and the captured values SHALL be used.
REQ-020 SHALL give back-to-back requests a minimum spacing of WAIT_CYCLES+2 cycles.
REQ-021 SHALL drive stall_o = req_i AND NOT ready_o, so the requester holds its MEM stage until the response.
REQ-022 SHALL form the word index from the captured addr[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL raise a fault when the captured addr[1:0]!=0, or when any captured address bit above the index is 1.
REQ-024 SHALL perform stores only on the RESP edge, writing the array only when there is no fault.
REQ-025 SHALL return array[index] on rdata_o for a fault-free load in RESP.
REQ-026 SHALL drive rdata_o to 0 for stores and faulted accesses.
REQ-027 SHALL drive err_o to 1 only in RESP of a faulted access; a faulted store SHALL leave the array unchanged.
REQ-028 SHALL drive rdata_o to 0 whenever ready_o is 0.
REQ-029 SHALL return the value most recently written for a load following a store to the same word (no stale data).

Reset
REQ-030 SHALL, on rst_i=0, immediately force state=IDLE, counter=0, ready_o=0, err_o=0, rdata_o=0 and clear the captured registers.
REQ-031 SHALL abandon any transaction in progress when reset is asserted mid-operation, with no array write.
REQ-032 SHALL NOT reset the storage array contents.
REQ-033 SHALL NOT accept a request on the first rising edge after rst_i deasserts; req_i SHALL be accepted from the second rising edge onward.

Structure
REQ-034 SHALL define the state enumeration and the constants WORD_BYTES=4 and DATA_W=32 in the shared package dmem_pkg.
REQ-035 SHALL implement the wait counter as the sub-module dmem_wait_ctr, with inputs load/enable and output done.
REQ-036 SHALL keep the storage array in a single always block with a synchronous write.

Verification
REQ-037 SHALL cover: WAIT_CYCLES=2, store 0xDEADBEEF to address 0x10 in cycle 5 -> ready_o=1 in cycle 8, err_o=0, stall_o=1 in cycles 5..7.
REQ-038 SHALL cover: a load from 0x10 after the store above -> rdata_o=0xDEADBEEF with ready_o, 3 cycles after acceptance.
REQ-039 SHALL cover: a load from 0x13 (misaligned) -> err_o=1, rdata_o=0; the word at 0x10 is unchanged on reread.
REQ-040 SHALL cover: DEPTH_WORDS=128, store to 0x200 (out of range) -> err_o=1; a subsequent load of 0x0 returns its prior value.
REQ-041 SHALL cover: rst_i pulled low during WAIT of a store to 0x20 -> ready_o never asserts, and a later load of 0x20 returns its old value.
REQ-042 SHALL cover: WAIT_CYCLES=0, req_i held high continuously -> ready_o pulses every 2 cycles and requests in RESP cycles are not double-counted.
